// File: rtl/zbt_bank_arb_if.sv
// Bus bundle between the display/pixel paths, the ZBT bank 1 pins and the bank arbiter.
interface zbt_bank_arb_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 19,
  parameter int DW         = 36
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] zbt_addr;
  logic          zbt_we;
  logic [DW-1:0] zbt_wdata;
  logic          zbt_drive;
  logic [DW-1:0] zbt_rdata;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          clr_overflow;

  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_data, zbt_rdata, clr_overflow,
    input  rd_data, rd_valid, zbt_addr, zbt_we, zbt_wdata, zbt_drive, fifo_level, overflow
  );

  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data, zbt_rdata, clr_overflow,
    output rd_data, rd_valid, zbt_addr, zbt_we, zbt_wdata, zbt_drive, fifo_level, overflow
  );
endinterface

// File: rtl/zbt_bank_arb.sv
// ZBT bank 1 arbiter: display reads win every slot, pixel writes are queued and drained
// into idle slots, with pipelined write-data timing and fixed-latency read return.
module zbt_bank_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int LAT        = 2,
  parameter int AW         = 19,
  parameter int DW         = 36
) (
  input  logic          clk,
  input  logic          reset,
  zbt_bank_arb_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;
  fifo_state_e state_q, state_d;

  logic [AW-1:0] mem_addr [FIFO_DEPTH];
  logic [DW-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          pop, push, drop;

  logic [LAT-1:0] wr_vld_p;
  logic [DW-1:0]  wr_dat_p [LAT];
  logic [LAT:0]   rd_vld_p;
  logic           rd_cap_vld;
  logic [DW-1:0]  rd_cap_dat;

  always_comb begin
    pop     = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    level_d = level_q;
    state_d = state_q;
    pop  = !bus.rd_req && (state_q != EMPTY);
    push = bus.wr_en && ((state_q != FULL) || pop);
    drop = bus.wr_en && !push;
    if (push && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !push)
      level_d = level_q - LW'(1);
    if (level_d == '0)
      state_d = EMPTY;
    else if (level_d == LW'(FIFO_DEPTH))
      state_d = FULL;
    else
      state_d = PARTIAL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      level_q      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)
        bus.overflow <= 1'b1;
      else if (bus.clr_overflow)
        bus.overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.wr_addr;
      mem_data[wr_ptr] <= bus.wr_data;
    end
  end

  assign bus.fifo_level = level_q;

  // p0: command slot onto the ZBT pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.zbt_addr <= '0;
      bus.zbt_we   <= 1'b0;
    end else begin
      bus.zbt_we <= pop;
      if (bus.rd_req)
        bus.zbt_addr <= bus.rd_addr;
      else if (pop)
        bus.zbt_addr <= mem_addr[rd_ptr];
    end
  end

  // p1..pLAT: write-data and read-tag latency pipelines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_p      <= '0;
      rd_vld_p      <= '0;
      rd_cap_vld    <= 1'b0;
      bus.zbt_drive <= 1'b0;
      bus.zbt_wdata <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      wr_vld_p[0] <= pop;
      for (int i = 1; i < LAT; i++) wr_vld_p[i] <= wr_vld_p[i-1];
      rd_vld_p[0] <= bus.rd_req;
      for (int i = 1; i <= LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
      bus.zbt_drive <= wr_vld_p[LAT-1];
      if (wr_vld_p[LAT-1]) bus.zbt_wdata <= wr_dat_p[LAT-1];
      rd_cap_vld   <= rd_vld_p[LAT];
      bus.rd_valid <= rd_cap_vld;
      if (rd_cap_vld) bus.rd_data <= rd_cap_dat;
    end
  end

  always_ff @(posedge clk) begin
    wr_dat_p[0] <= mem_data[rd_ptr];
    for (int i = 1; i < LAT; i++) wr_dat_p[i] <= wr_dat_p[i-1];
    rd_cap_dat <= bus.zbt_rdata;
  end
endmodule

// File: tb/tb_zbt_bank_arb.sv
// Directed bench for zbt_bank_arb; the ZBT read bus returns the address seen LAT cycles earlier.
module tb_zbt_bank_arb;
  localparam int FIFO_DEPTH = 4;
  localparam int LAT        = 2;
  localparam int AW         = 19;
  localparam int DW         = 36;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zbt_bank_arb_if #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW), .DW(DW)) bus ();

  zbt_bank_arb #(.FIFO_DEPTH(FIFO_DEPTH), .LAT(LAT), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: data for the address on the pins appears LAT(=2) cycles later.
  logic [AW-1:0] addr_d1, addr_d2;
  always @(posedge clk) begin
    addr_d1 <= bus.zbt_addr;
    addr_d2 <= addr_d1;
  end
  assign bus.zbt_rdata = DW'(addr_d2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rr, input logic [AW-1:0] ra,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.rd_req  = rr;
    bus.rd_addr = ra;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
  endtask

  initial begin
    reset = 1'b1;
    bus.clr_overflow = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    step();
    check("rst_level",    bus.fifo_level, 0);
    check("rst_we",       bus.zbt_we,     0);
    check("rst_addr",     bus.zbt_addr,   0);
    check("rst_drive",    bus.zbt_drive,  0);
    check("rst_wdata",    bus.zbt_wdata,  0);
    check("rst_rd_valid", bus.rd_valid,   0);
    check("rst_rd_data",  bus.rd_data,    0);
    check("rst_overflow", bus.overflow,   0);
    reset = 1'b0;
    step();

    // Reads only: three back-to-back reads, rd_valid from the 4th edge on
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(32'h10 + i), 1'b0, '0, '0);
      step();
      check("rd_cmd_we",   bus.zbt_we,   0);
      check("rd_cmd_addr", bus.zbt_addr, 64'h10 + i);
      check("rd_early_vld", bus.rd_valid, 0);
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    check("rd_vld_e4", bus.rd_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_vld",  bus.rd_valid, 1);
      check("rd_data", bus.rd_data,  64'h10 + i);
      check("rd_no_we", bus.zbt_we,  0);
    end
    step();
    check("rd_vld_end", bus.rd_valid, 0);

    // Write drain
    drive(1'b0, '0, 1'b1, 19'h12345, 36'hABCDE1234);
    step();
    check("wr_level1", bus.fifo_level, 1);
    check("wr_no_bypass", bus.zbt_we, 0);
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    check("wr_we",     bus.zbt_we,     1);
    check("wr_addr",   bus.zbt_addr,   64'h12345);
    check("wr_level0", bus.fifo_level, 0);
    step();
    check("wr_we_off",   bus.zbt_we,    0);
    check("wr_drive_e1", bus.zbt_drive, 0);
    step();
    check("wr_drive", bus.zbt_drive, 1);
    check("wr_wdata", bus.zbt_wdata, 64'hABCDE1234);
    step();
    check("wr_drive_off", bus.zbt_drive, 0);
    check("wr_wdata_hold", bus.zbt_wdata, 64'hABCDE1234);

    // Priority: writes starve under continuous reads, then drain in order
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 19'h100, 1'b1, AW'(32'h200 + i), DW'(i + 1));
      step();
      check("pri_we_low", bus.zbt_we, 0);
    end
    drive(1'b1, 19'h100, 1'b0, '0, '0);
    step();
    check("pri_we_low", bus.zbt_we, 0);
    check("pri_level3", bus.fifo_level, 3);
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pri_drain_we",   bus.zbt_we,     1);
      check("pri_drain_addr", bus.zbt_addr,   64'h200 + i);
      check("pri_drain_lvl",  bus.fifo_level, 2 - i);
    end
    step();
    check("pri_drain_done", bus.zbt_we, 0);
    for (int i = 0; i < 6; i++) step();

    // Overflow: five pushes under reads, then a drop coinciding with a clear
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 19'h100, 1'b1, AW'(32'h300 + i), DW'(i));
      step();
    end
    check("ovf_level", bus.fifo_level, 4);
    check("ovf_set",   bus.overflow,   1);
    drive(1'b1, 19'h100, 1'b1, 19'h3FF, 36'h0);
    bus.clr_overflow = 1'b1;
    step();
    check("ovf_set_wins", bus.overflow, 1);
    check("ovf_level2",   bus.fifo_level, 4);
    drive(1'b1, 19'h100, 1'b0, '0, '0);
    step();
    bus.clr_overflow = 1'b0;
    check("ovf_cleared", bus.overflow, 0);
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("ovf_drain_we",   bus.zbt_we,   1);
      check("ovf_drain_addr", bus.zbt_addr, 64'h300 + i);
    end
    step();
    check("ovf_5th_absent", bus.zbt_we, 0);
    check("ovf_level0",     bus.fifo_level, 0);
    for (int i = 0; i < 4; i++) step();

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 19'h100, 1'b1, AW'(32'h400 + i), DW'(i));
      step();
    end
    check("full_level", bus.fifo_level, 4);
    drive(1'b0, '0, 1'b1, 19'h404, 36'h4);
    step();
    check("full_pp_level", bus.fifo_level, 4);
    check("full_pp_ovf",   bus.overflow,   0);
    check("full_pp_we",    bus.zbt_we,     1);
    check("full_pp_addr",  bus.zbt_addr,   64'h400);
    drive(1'b0, '0, 1'b0, '0, '0);
    for (int i = 1; i < 5; i++) begin
      step();
      check("full_drain_addr", bus.zbt_addr, 64'h400 + i);
      check("full_drain_we",   bus.zbt_we,   1);
    end
    step();
    check("full_level0", bus.fifo_level, 0);
    for (int i = 0; i < 4; i++) step();

    // Reset with two reads and one write in flight
    drive(1'b1, 19'h500, 1'b1, 19'h600, 36'h5A);
    step();
    drive(1'b1, 19'h501, 1'b0, '0, '0);
    step();
    drive(1'b0, '0, 1'b0, '0, '0);
    step();
    check("mid_we_pre", bus.zbt_we, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_addr",  bus.zbt_addr,   0);
    check("mid_rst_we",    bus.zbt_we,     0);
    check("mid_rst_drive", bus.zbt_drive,  0);
    check("mid_rst_wdata", bus.zbt_wdata,  0);
    check("mid_rst_vld",   bus.rd_valid,   0);
    check("mid_rst_rdata", bus.rd_data,    0);
    check("mid_rst_level", bus.fifo_level, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_vld",   bus.rd_valid,  0);
      check("post_rst_drive", bus.zbt_drive, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/zbt_bank_arb.md
Name: zbt_bank_arb

Overview:
Arbitrates the single-ported ZBT bank 1 between the display read path and the pixel-processing write path. The write side carries processed two-pixel words with their addresses. Display reads have absolute priority. Writes are buffered in a small FIFO and drained into idle cycles. The block also generates the ZBT pipelined write-data timing and returns read data with fixed latency.

Parameters:
FIFO_DEPTH, 4, write FIFO entries; power of 2, minimum 2
LAT, 2, ZBT pipeline latency in cycles, from command on pins to data on bus; minimum 1
AW, 19, address width
DW, 36, data word width (two 18-bit pixels)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rd_req  in  1  display read request for this cycle
rd_addr  in  AW  display read address
rd_data  out  DW  returned read word, registered
rd_valid  out  1  rd_data valid strobe
wr_en  in  1  processed word push strobe; no backpressure
wr_addr  in  AW  write address
wr_data  in  DW  write word
zbt_addr  out  AW  ZBT address, registered
zbt_we  out  1  ZBT write command, active-high; pin inversion is done outside this block
zbt_wdata  out  DW  ZBT write data
zbt_drive  out  1  tri-state enable for zbt_wdata
zbt_rdata  in  DW  ZBT read data bus
fifo_level  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy
overflow  out  1  sticky flag: a write was dropped
clr_overflow  in  1  clears overflow

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - FIFO pointers; fifo_level = 0
  - zbt_addr = 0, zbt_we = 0, zbt_wdata = 0, zbt_drive = 0
  - rd_data = 0, rd_valid = 0, overflow = 0
  - all internal latency pipelines, so in-flight reads and writes are discarded; rd_valid stays 0 after reset is released.
- Command slot, decided every cycle from values sampled at the clock edge:
  - If rd_req = 1: issue a read. zbt_addr <= rd_addr, zbt_we <= 0.
  - Else if FIFO is not empty: pop the head entry. zbt_addr <= head addr, zbt_we <= 1, and the head data enters the write-data pipeline.
  - Else: idle. zbt_we <= 0 and zbt_addr holds its previous value.
- The FIFO state machine has three states: EMPTY, PARTIAL, FULL, derived from the occupancy count.
- Push rules:
  - wr_en is accepted if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - wr_en when level = FIFO_DEPTH with no pop: the word is dropped, level is unchanged, and overflow is set.
  - Push and pop in the same cycle: level is unchanged and both operations succeed, including at FULL.
  - A pushed word becomes eligible for pop no earlier than the next cycle; there is no bypass.
- Write data timing:
  - zbt_wdata = data of the write issued on zbt_we exactly LAT cycles earlier.
  - zbt_drive = 1 in exactly that cycle, otherwise 0.
  - zbt_wdata holds its previous value when zbt_drive = 0.
- Read return timing:
  - zbt_rdata is captured LAT cycles after the read command appeared on zbt_addr.
  - rd_valid and rd_data are registered one cycle later.
  - Total latency: rd_valid rises LAT+2 cycles after the edge that sampled rd_req = 1 (4 cycles at default).
  - Back-to-back reads give back-to-back rd_valid pulses.
- Writes starve while rd_req is held continuously. Whether writes drop during a long read burst is determined by the FIFO; the arbiter never reorders or overrides a read.
- Overflow flag: clr_overflow clears it. If a set event and clr_overflow occur in the same cycle, set wins.
- Addresses pass through unmodified; there is no wrap or range check.
- Writes leave the FIFO in push order. Read/write hazards to the same address are not resolved; the write path and display path use disjoint frame regions.

Test Plan:
- Reads only: rd_req held 3 cycles with addr 0x00010, 0x00011, 0x00012 and zbt_rdata modelled = addr -> rd_valid high for 3 cycles starting 4 cycles after the first rd_req; rd_data = 0x00010, 0x00011, 0x00012; zbt_we never 1.
- Write drain: one wr_en, addr 0x12345, data 0xABCDE1234, rd_req = 0 -> next cycle zbt_we = 1 with zbt_addr = 0x12345; 2 cycles later zbt_drive = 1 with zbt_wdata = 0xABCDE1234; fifo_level returns 0.
- Priority: rd_req = 1 continuously with 3 wr_en pulses -> zbt_we stays 0 and fifo_level = 3; when rd_req drops, 3 consecutive writes issue in push order.
- Overflow: rd_req held high, 5 wr_en pushes -> fifo_level = 4, overflow = 1, 5th word absent from the drain. clr_overflow pulsed on the same cycle as a 6th dropped push -> overflow stays 1.
- Full with simultaneous push/pop: FIFO full, rd_req = 0, wr_en = 1 -> push accepted, fifo_level stays 4, overflow stays 0.
- Reset mid-operation: assert reset while 2 reads and 1 write are in flight -> all outputs 0 immediately; no rd_valid or zbt_drive pulse after release.
